ps2_host_tx: RTL

//  PS/2 host-to-device transmitter. It is the send side of the keyboard link: it sends

---
 rtl/ps2_host_tx_if.sv | 17 +
 rtl/ps2_host_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
//   Byte handshake between a command source (CPU bus controller or a fixed
//   command sequencer) and the PS/2 host transmitter.
//   Signals:
//     tx_data  [7:0]  command byte            (master -> slave)
//     tx_valid        byte offered            (master -> slave)
//     tx_ready        transmitter can accept  (slave  -> master)
//   A byte moves on a clock edge where tx_valid && tx_ready. The master
//   holds tx_valid and tx_data until that edge.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set
//   LEDs, 0xFF reset) to the keyboard using the host request-to-send sequence:
//   inhibit the clock, drive the start bit, release the clock, then shift the
//   data out on the falling edges the device generates.
//   Ports:
//     CLOCK_50     in   system clock, 50 MHz
//     reset        in   asynchronous, active-low
//     tx_if        slave side of the byte handshake (tx_data/tx_valid/tx_ready)
//     ps2_clk_in   in   raw PS2_CLK pin level (asynchronous)
//     ps2_dat_in   in   raw PS2_DAT pin level (asynchronous)
//     ps2_clk_oe   out  1 = pull PS2_CLK low, 0 = release
//     ps2_dat_oe   out  1 = pull PS2_DAT low, 0 = release
//     busy         out  frame in progress; the receiver ignores the lines meanwhile
//     tx_done      out  one-cycle pulse, device acknowledged the frame
//     tx_error     out  one-cycle pulse, device nacked or the frame timed out
//   Parameters:
//     INHIBIT_CYC  cycles the clock line is held low before request-to-send
//     TIMEOUT_CYC  cycles allowed from request-to-send until the lines go idle
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 750000
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    ps2_host_tx_if.slave tx_if,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe,
    output logic         busy,
    output logic         tx_done,
    output logic         tx_error
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] REQ       = 3'd2;
    localparam logic [2:0] DATA      = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;
    localparam logic [2:0] ERR       = 3'd7;

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYC - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYC - 1);
    localparam logic [19:0] CNT_MAX      = 20'hF_FFFF;

    // PS/2 uses odd parity: the parity bit makes the count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    logic [2:0]  clk_sync_r;
    logic [1:0]  dat_sync_r;
    logic [2:0]  state_r;
    logic [2:0]  state_nx_s;
    logic [19:0] cnt_r;
    logic [19:0] cnt_nx_s;
    logic [19:0] cnt_inc_s;
    logic [3:0]  edge_r;
    logic [3:0]  edge_nx_s;
    logic [9:0]  shift_r;
    logic [9:0]  shift_nx_s;
    logic        dat_oe_nx_s;
    logic        clk_oe_r;
    logic        dat_oe_r;
    logic        busy_r;
    logic        done_r;
    logic        error_r;
    logic        ready_r;
    logic        clk_s;
    logic        dat_s;
    logic        fall_s;
    logic        accept_s;
    logic        timeout_s;

    assign clk_s     = clk_sync_r[1];
    assign dat_s     = dat_sync_r[1];
    assign fall_s    = clk_sync_r[2] & ~clk_sync_r[1];
    assign accept_s  = tx_if.tx_valid & ready_r;
    assign timeout_s = (cnt_r == TIMEOUT_LAST);

    // Two-stage pin synchronisers; the third clock stage holds the previous synchronised level.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            clk_sync_r <= 3'b111;
            dat_sync_r <= 2'b11;
        end else begin
            clk_sync_r <= {clk_sync_r[1:0], ps2_clk_in};
            dat_sync_r <= {dat_sync_r[0], ps2_dat_in};
        end
    end

    // Saturating increment shared by the inhibit and timeout phases.
    always_comb begin
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + 20'd1;
        end
    end

    // Next-state logic: frame sequencing, bit shifting and timeout supervision.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_inc_s;
        edge_nx_s   = edge_r;
        shift_nx_s  = shift_r;
        dat_oe_nx_s = dat_oe_r;
        case (state_r)
            IDLE: begin
                cnt_nx_s    = 20'd0;
                dat_oe_nx_s = 1'b0;
                if (accept_s) begin
                    state_nx_s = INHIBIT;
                    shift_nx_s = {1'b1, odd_parity(tx_if.tx_data), tx_if.tx_data};
                end else begin
                    state_nx_s = IDLE;
                end
            end
            INHIBIT: begin
                if (cnt_r == INHIBIT_LAST) begin
                    // Start bit goes out together with the clock release.
                    state_nx_s  = REQ;
                    cnt_nx_s    = 20'd0;
                    edge_nx_s   = 4'd0;
                    dat_oe_nx_s = 1'b1;
                end else begin
                    state_nx_s = INHIBIT;
                end
            end
            REQ: begin
                if (timeout_s) begin
                    state_nx_s  = ERR;
                    dat_oe_nx_s = 1'b0;
                end else begin
                    state_nx_s = DATA;
                end
            end
            DATA: begin
                // Timeout wins over a falling edge in the same cycle.
                if (timeout_s) begin
                    state_nx_s  = ERR;
                    dat_oe_nx_s = 1'b0;
                end else if (fall_s) begin
                    // Edges 1..8 data LSB first, 9 parity, 10 stop (released line).
                    dat_oe_nx_s = ~shift_r[0];
                    shift_nx_s  = {1'b0, shift_r[9:1]};
                    edge_nx_s   = edge_r + 4'd1;
                    if (edge_r == 4'd9) begin
                        state_nx_s = ACK;
                    end else begin
                        state_nx_s = DATA;
                    end
                end else begin
                    state_nx_s = DATA;
                end
            end
            ACK: begin
                if (timeout_s) begin
                    state_nx_s  = ERR;
                    dat_oe_nx_s = 1'b0;
                end else if (fall_s) begin
                    edge_nx_s = 4'd11;
                    if (dat_s) begin
                        state_nx_s = ERR;
                    end else begin
                        state_nx_s = WAIT_IDLE;
                    end
                end else begin
                    state_nx_s = ACK;
                end
            end
            WAIT_IDLE: begin
                // Further clock edges here are ignored; only both lines idle ends the frame.
                if (timeout_s) begin
                    state_nx_s  = ERR;
                    dat_oe_nx_s = 1'b0;
                end else if (clk_s && dat_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = WAIT_IDLE;
                end
            end
            DONE: begin
                state_nx_s  = IDLE;
                cnt_nx_s    = 20'd0;
                dat_oe_nx_s = 1'b0;
            end
            ERR: begin
                state_nx_s  = IDLE;
                cnt_nx_s    = 20'd0;
                dat_oe_nx_s = 1'b0;
            end
            default: begin
                state_nx_s  = IDLE;
                cnt_nx_s    = 20'd0;
                dat_oe_nx_s = 1'b0;
            end
        endcase
    end

    // State, counters and frame shift register.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 20'd0;
            edge_r  <= 4'd0;
            shift_r <= 10'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            edge_r  <= edge_nx_s;
            shift_r <= shift_nx_s;
        end
    end

    // Outputs registered from the next state so they change on the same edge as the state.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            clk_oe_r <= 1'b0;
            dat_oe_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            clk_oe_r <= (state_nx_s == INHIBIT);
            dat_oe_r <= dat_oe_nx_s;
            busy_r   <= (state_nx_s != IDLE);
            done_r   <= (state_nx_s == DONE);
            error_r  <= (state_nx_s == ERR);
            ready_r  <= (state_nx_s == IDLE);
        end
    end

    assign ps2_clk_oe     = clk_oe_r;
    assign ps2_dat_oe     = dat_oe_r;
    assign busy           = busy_r;
    assign tx_done        = done_r;
    assign tx_error       = error_r;
    assign tx_if.tx_ready = ready_r;

endmodule
